// File: rtl/parametric_memory.sv
// rtl/parametric_memory.sv - parametrised simple-dual-port RAM with lane enables, write-first forwarding and clear sweep
module parametric_memory #(
  parameter int                    DATA_WIDTH      = 24,
  parameter int                    LANE_WIDTH      = 8,
  parameter int                    ADDR_WIDTH      = 9,
  parameter int                    OUTPUT_REGISTER = 0,
  parameter int                    CLEAR_ON_RESET  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE     = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               ready,
  input  logic                               perform_read,
  input  logic [ADDR_WIDTH-1:0]              read_address,
  output logic [DATA_WIDTH-1:0]              read_data,
  output logic                               read_data_ready,
  input  logic                               perform_write,
  input  logic [ADDR_WIDTH-1:0]              write_address,
  input  logic [DATA_WIDTH-1:0]              write_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   write_enable
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_accept, wr_accept;
  logic [DATA_WIDTH-1:0]   s1_data_q;
  logic                    s1_valid_q;

  assign rd_accept = ready_q & perform_read;
  assign wr_accept = ready_q & perform_write;
  assign ready     = ready_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN:  ready_d = 1'b1;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Storage itself is never reset; only the sweep or accepted writes touch it.
  always_ff @(posedge clock) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_cnt_q] <= CLEAR_VALUE;
    end else if (wr_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (write_enable[i]) begin
          mem_q[write_address][i*LANE_WIDTH +: LANE_WIDTH] <= write_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Same-edge collision: enabled lanes take the incoming data, others the stored word.
  always_comb begin
    rd_word = mem_q[read_address];
    for (int i = 0; i < LANES; i++) begin
      if (wr_accept && write_enable[i] && (write_address == read_address)) begin
        rd_word[i*LANE_WIDTH +: LANE_WIDTH] = write_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_accept;
      if (rd_accept) begin
        s1_data_q <= rd_word;
      end
    end
  end

  generate
    if (OUTPUT_REGISTER != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_data_q;
      logic                  out_valid_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            out_data_q <= s1_data_q;
          end
        end
      end

      assign read_data       = out_data_q;
      assign read_data_ready = out_valid_q;
    end else begin : g_no_out_reg
      assign read_data       = s1_data_q;
      assign read_data_ready = s1_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_parametric_memory.sv
// tb/tb_parametric_memory.sv - self-checking bench for parametric_memory
module tb_parametric_memory;

  localparam int DW    = 24;
  localparam int LW    = 8;
  localparam int AW    = 9;
  localparam int LANES = 3;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;

  initial forever #5 clk = ~clk;

  logic             perform_read  = 1'b0;
  logic             perform_write = 1'b0;
  logic [AW-1:0]    read_address  = '0;
  logic [AW-1:0]    write_address = '0;
  logic [DW-1:0]    write_data    = '0;
  logic [LANES-1:0] write_enable  = '0;
  logic             ready_a, rdr_a, ready_b, rdr_b;
  logic [DW-1:0]    rd_a, rd_b;

  logic             c_perform_read  = 1'b0;
  logic             c_perform_write = 1'b0;
  logic [3:0]       c_read_address  = '0;
  logic [3:0]       c_write_address = '0;
  logic [31:0]      c_write_data    = '0;
  logic [3:0]       c_write_enable  = '0;
  logic             ready_c, rdr_c;
  logic [31:0]      rd_c;

  parametric_memory #(.OUTPUT_REGISTER(0)) dut_a (
    .clock(clk), .reset(rst), .ready(ready_a),
    .perform_read(perform_read), .read_address(read_address),
    .read_data(rd_a), .read_data_ready(rdr_a),
    .perform_write(perform_write), .write_address(write_address),
    .write_data(write_data), .write_enable(write_enable)
  );

  parametric_memory #(.OUTPUT_REGISTER(1)) dut_b (
    .clock(clk), .reset(rst), .ready(ready_b),
    .perform_read(perform_read), .read_address(read_address),
    .read_data(rd_b), .read_data_ready(rdr_b),
    .perform_write(perform_write), .write_address(write_address),
    .write_data(write_data), .write_enable(write_enable)
  );

  parametric_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CLEAR_ON_RESET(0)) dut_c (
    .clock(clk), .reset(rst), .ready(ready_c),
    .perform_read(c_perform_read), .read_address(c_read_address),
    .read_data(rd_c), .read_data_ready(rdr_c),
    .perform_write(c_perform_write), .write_address(c_write_address),
    .write_data(c_write_data), .write_enable(c_write_enable)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain word array, a count of clean edges since reset,
  // and the list of read results in flight (index 0 = latency 1, index 1 = latency 2).
  bit [DW-1:0] model_mem [DEPTH];
  int          clr_edges  = 0;
  bit          model_live = 1'b0;
  bit          exp_ready  = 1'b0;
  bit          exp_rdr_a  = 1'b0;
  bit          exp_rdr_b  = 1'b0;
  bit [DW-1:0] exp_data_a = '0;
  bit [DW-1:0] exp_data_b = '0;
  bit          pend_valid = 1'b0;
  bit [DW-1:0] pend_data  = '0;
  bit          m_acc;
  bit [DW-1:0] m_word;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      clr_edges  = 0;
      exp_ready  = 1'b0;
      exp_rdr_a  = 1'b0;
      exp_rdr_b  = 1'b0;
      exp_data_a = '0;
      exp_data_b = '0;
      pend_valid = 1'b0;
      model_live = 1'b1;
    end else begin
      m_acc  = exp_ready && perform_read;
      m_word = model_mem[read_address];
      for (int i = 0; i < LANES; i++)
        if (exp_ready && perform_write && write_enable[i] && write_address == read_address)
          m_word[i*LW +: LW] = write_data[i*LW +: LW];
      if (exp_ready && perform_write)
        for (int i = 0; i < LANES; i++)
          if (write_enable[i]) model_mem[write_address][i*LW +: LW] = write_data[i*LW +: LW];
      exp_rdr_b = pend_valid;
      if (pend_valid) exp_data_b = pend_data;
      pend_valid = m_acc;
      if (m_acc) pend_data = m_word;
      exp_rdr_a = m_acc;
      if (m_acc) exp_data_a = m_word;
      if (!exp_ready) begin
        clr_edges++;
        if (clr_edges == DEPTH) begin
          exp_ready = 1'b1;
          foreach (model_mem[j]) model_mem[j] = '0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (model_live) begin
      chk("ready_a", ready_a, exp_ready);
      chk("ready_b", ready_b, exp_ready);
      chk("rdr_a", rdr_a, exp_rdr_a);
      chk("rdr_b", rdr_b, exp_rdr_b);
      chk("rdata_a", rd_a, exp_data_a);
      chk("rdata_b", rd_b, exp_data_b);
    end
  end

  task automatic cycle(input bit rd, input int ra, input bit wr, input int wa,
                       input logic [DW-1:0] wd, input logic [LANES-1:0] we);
    @(negedge clk);
    perform_read  = rd;
    read_address  = ra[AW-1:0];
    perform_write = wr;
    write_address = wa[AW-1:0];
    write_data    = wd;
    write_enable  = we;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 0, 1'b0, 0, '0, '0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 600; i++) begin
      idle();
      if (i == 1) chk("c_ready_edge1", ready_c, 1'b1);
      if (ready_a) begin
        n = i;
        break;
      end
    end
    chk(name, n, 512);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 9))
      0:       return 0;
      1:       return 511;
      2:       return 255;
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    idle();
    chk("reset_ready_a", ready_a, 1'b0);
    chk("reset_ready_c", ready_c, 1'b0);
    chk("reset_rdata_a", rd_a, 24'h0);
    rst = 1'b0;
    wait_ready("clear_len");

    cycle(1'b1, 0, 1'b0, 0, '0, '0);
    chk("rd0_rdr", rdr_a, 1'b1);
    chk("rd0_data", rd_a, 24'h000000);
    cycle(1'b1, 255, 1'b0, 0, '0, '0);
    chk("rd255_data", rd_a, 24'h000000);
    cycle(1'b1, 511, 1'b0, 0, '0, '0);
    chk("rd511_data", rd_a, 24'h000000);
    idle();
    chk("rdr_drop", rdr_a, 1'b0);

    cycle(1'b0, 0, 1'b1, 5, 24'hAABBCC, 3'b111);
    cycle(1'b0, 0, 1'b1, 5, 24'h112233, 3'b010);
    cycle(1'b1, 5, 1'b0, 0, '0, '0);
    chk("lane_write", rd_a, 24'hAA22CC);

    cycle(1'b0, 0, 1'b1, 7, 24'h010203, 3'b111);
    cycle(1'b1, 7, 1'b1, 7, 24'hFFEEDD, 3'b101);
    chk("collision_a", rd_a, 24'hFF02DD);
    idle();
    chk("collision_b", rd_b, 24'hFF02DD);
    cycle(1'b1, 7, 1'b0, 0, '0, '0);
    chk("collision_stored", rd_a, 24'hFF02DD);

    c_perform_write = 1'b1;
    c_write_address = 4'd15;
    c_write_data    = 32'hDEADBEEF;
    c_write_enable  = 4'hF;
    idle();
    c_perform_write = 1'b0;
    c_perform_read  = 1'b1;
    c_read_address  = 4'd15;
    idle();
    c_perform_read  = 1'b0;
    chk("c_rdr", rdr_c, 1'b1);
    chk("c_data", rd_c, 32'hDEADBEEF);

    cycle(1'b0, 0, 1'b1, 1, 24'h111111, 3'b111);
    cycle(1'b0, 0, 1'b1, 2, 24'h222222, 3'b111);
    cycle(1'b0, 0, 1'b1, 3, 24'h333333, 3'b111);
    cycle(1'b1, 1, 1'b0, 0, '0, '0);
    chk("b2b_lat_b", rdr_b, 1'b0);
    cycle(1'b1, 2, 1'b0, 0, '0, '0);
    chk("b2b_rdr1", rdr_b, 1'b1);
    chk("b2b_data1", rd_b, 24'h111111);
    cycle(1'b1, 3, 1'b0, 0, '0, '0);
    chk("b2b_rdr2", rdr_b, 1'b1);
    chk("b2b_data2", rd_b, 24'h222222);
    idle();
    chk("b2b_rdr3", rdr_b, 1'b1);
    chk("b2b_data3", rd_b, 24'h333333);
    idle();
    chk("b2b_end", rdr_b, 1'b0);
    chk("b2b_hold", rd_b, 24'h333333);

    for (int n = 0; n < 1500; n++) begin
      int ra, wa;
      ra = pick();
      wa = ($urandom_range(0, 3) == 0) ? ra : pick();
      cycle($urandom_range(0, 1) == 1, ra, $urandom_range(0, 1) == 1, wa,
            DW'($urandom), LANES'($urandom_range(0, 7)));
    end

    cycle(1'b1, 1, 1'b0, 0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_rdr_b", rdr_b, 1'b0);
    chk("midrst_data_b", rd_b, 24'h0);
    chk("midrst_data_a", rd_a, 24'h0);
    chk("midrst_ready", ready_a, 1'b0);
    idle();
    idle();
    rst = 1'b0;
    wait_ready("reclear_len");
    cycle(1'b1, 5, 1'b0, 0, '0, '0);
    chk("reclear_data", rd_a, 24'h000000);

    for (int n = 0; n < 300; n++) begin
      cycle($urandom_range(0, 1) == 1, pick(), $urandom_range(0, 1) == 1, pick(),
            DW'($urandom), LANES'($urandom_range(0, 7)));
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parametric_memory.md
# parametric_memory

Parametrised simple-dual-port block RAM with one read port and one write port, for iCE40-class embedded RAM. It generalises the fixed 512×24 byte-laned memory: data width, lane width, depth and read latency are parameters. It adds per-lane write enables, write-first forwarding on same-address collisions, and an optional clear-on-reset sweep with a `ready` status. It sits between producers/consumers (pixel buffers, FIFOs, frame stores) and the inferred RAM primitives.

## Interface
- DATA_WIDTH, 24, read/write word width; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 8, width of one write-enable lane; LANES = DATA_WIDTH/LANE_WIDTH
- ADDR_WIDTH, 9, address width; depth = 2**ADDR_WIDTH
- OUTPUT_REGISTER, 0, 0: read latency 1 cycle; 1: extra output register, latency 2 cycles
- CLEAR_ON_RESET, 1, 1: after reset, every word is written with CLEAR_VALUE before `ready`
- CLEAR_VALUE, 0, DATA_WIDTH-bit fill value for the clear sweep

- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- ready  output  1  high when read/write requests are accepted
- perform_read  input  1  read request, sampled on rising clock edge
- read_address  input  ADDR_WIDTH  read address
- read_data  output  DATA_WIDTH  read result, holds last value between reads
- read_data_ready  output  1  one-cycle strobe per accepted read, aligned with read_data
- perform_write  input  1  write request; must be held low when the port is unused
- write_address  input  ADDR_WIDTH  write address
- write_data  input  DATA_WIDTH  write data
- write_enable  input  LANES  per-lane enable; bit i gates bits [i*LANE_WIDTH +: LANE_WIDTH]

## Operation
- State machine: CLEAR, RUN.
- Reset asserted (async):
  - state=CLEAR if CLEAR_ON_RESET, else RUN.
  - Clear counter=0; ready=0; read_data=0; read_data_ready=0; all pipeline valids=0.
  - Memory contents are not otherwise changed by reset.
- CLEAR:
  - Each edge writes CLEAR_VALUE to all lanes at the counter address, then the counter increments.
  - After writing address 2**ADDR_WIDTH-1, state goes to RUN.
  - perform_read/perform_write are ignored; no read_data_ready is produced.
- RUN:
  - ready=1.
  - Write: on an edge with perform_write=1, lane i at write_address is updated only where write_enable[i]=1. perform_write=1 with write_enable=0 is a no-op.
  - Read: on an edge with perform_read=1, the word at read_address is fetched.
- Collision (read and write to the same address on the same edge):
  - Enabled lanes return the new write_data lane (write-first).
  - Disabled lanes return the stored old value.
- A write on a later edge does not alter an in-flight read result.
- Throughput: one read and one write per cycle, to any addresses.
- Reset mid-operation: in-flight reads are dropped, read_data_ready=0, and the clear sweep restarts from address 0.

## Timing
- Clear sweep takes exactly 2**ADDR_WIDTH cycles after reset deasserts.
  - ready rises on the edge that writes the last address.
  - First accepted request is on the following edge.
- CLEAR_ON_RESET=0: ready=1 from the first edge after reset deasserts.
- OUTPUT_REGISTER=0: read sampled at edge k drives read_data and read_data_ready=1 at edge k. They are valid for the cycle after edge k.
- OUTPUT_REGISTER=1: same read is presented at edge k+1.
  - read_data_ready is delayed identically, so it is always aligned with read_data.
- read_data_ready deasserts on the next edge when no read is pending.
- read_data changes only on edges that assert read_data_ready, and on reset.
- A write at edge k is visible to a non-colliding read sampled at edge k+1.

## Test plan
- Clear: defaults, reset pulse, wait 512 cycles -> ready=0 until the 512th edge after release. Then reads of addresses 0, 255 and 511 return 24'h000000 with read_data_ready after 1 cycle.
- Lane write: write 24'hAABBCC to address 5 with enable 3'b111, then 24'h112233 with enable 3'b010 -> read of address 5 returns 24'hAA22CC.
- Collision: address 7 holds 24'h010203; on the same edge write 24'hFFEEDD with enable 3'b101 and read address 7 -> read_data=24'hFF02DD.
- Latency and throughput, OUTPUT_REGISTER=1: back-to-back reads of addresses 1, 2, 3 -> read_data_ready high for 3 consecutive cycles starting 2 cycles after the first request, with data in order.
- Reset mid-burst: assert reset while a read is in flight -> read_data_ready never pulses for that read, read_data=0, and the clear sweep reruns for the full 512 cycles.
- CLEAR_ON_RESET=0, DATA_WIDTH=32, ADDR_WIDTH=4: ready=1 one edge after reset release. Write then read 32'hDEADBEEF at address 15 -> exact match.
